// File: rtl/hex_display_pkg.sv
// Shared constants for the DE1-SoC HEX digit driver: register map, CTRL bit
// positions and the hex-nibble to segment table (active-high, bit0=a .. bit6=g).
package hex_display_pkg;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_BRIGHT = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;

  localparam int CTRL_EN    = 0;
  localparam int CTRL_DEC   = 1;
  localparam int CTRL_BLINK = 2;

  // Entry 15 is listed first because this is a packed array.
  localparam logic [15:0][6:0] HEX_SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/hex_seg_decode.sv
// Combinational 4-bit nibble to 7-segment (active-high) decoder.
module hex_seg_decode
  import hex_display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = HEX_SEG_TABLE[nibble];

endmodule

// File: rtl/de1_soc_hex_display_driver.sv
// Drives one active-low DE1-SoC HEX digit from a PIO segment pattern, adding
// optional hex decode, PWM brightness, blink and period-aligned pattern updates.
module de1_soc_hex_display_driver
  import hex_display_pkg::*;
#(
  parameter int PWM_BITS  = 4,
  parameter int PRESCALE  = 64,
  parameter int BLINK_DIV = 25000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic [6:0]  seg_in,
  output logic [6:0]  hex_n
);

  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [PWM_BITS:0] BR_MAX   = {1'b1, {PWM_BITS{1'b0}}};
  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(PRESCALE - 1);
  localparam logic [BLK_W-1:0]  BLK_LAST = BLK_W'(BLINK_DIV - 1);

  logic [2:0]          ctrl;
  logic [PWM_BITS:0]   bright;
  logic [PWM_BITS:0]   bright_wr;
  logic [6:0]          seg_q;
  logic [6:0]          dec_pat;
  logic [6:0]          src_pat;
  logic [6:0]          shadow_pat;
  logic [PWM_BITS:0]   shadow_br;
  logic [PRE_W-1:0]    pre_cnt;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [BLK_W-1:0]    blink_cnt;
  logic                blink_phase;
  logic                wr_en;
  logic                ctrl_wr;
  logic                pre_wrap;
  logic                boundary;
  logic                pwm_on;
  logic                visible;

  hex_seg_decode u_decode (
    .nibble (seg_q[3:0]),
    .seg    (dec_pat)
  );

  assign wr_en     = chipselect && !write_n;
  assign ctrl_wr   = wr_en && (address == ADDR_CTRL);
  assign bright_wr = (writedata > 32'(BR_MAX)) ? BR_MAX : writedata[PWM_BITS:0];
  assign src_pat   = ctrl[CTRL_DEC] ? dec_pat : seg_q;
  assign pre_wrap  = (pre_cnt == PRE_LAST);
  assign boundary  = pre_wrap && (pwm_cnt == {PWM_BITS{1'b1}});
  assign pwm_on    = ({1'b0, pwm_cnt} < shadow_br);
  assign visible   = ctrl[CTRL_EN] && pwm_on && !(ctrl[CTRL_BLINK] && blink_phase);

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl   <= 3'b001;
      bright <= BR_MAX;
    end else if (wr_en) begin
      if (address == ADDR_CTRL) begin
        ctrl <= writedata[2:0];
      end else if (address == ADDR_BRIGHT) begin
        bright <= bright_wr;
      end
    end
  end

  // Pattern and brightness only change at a period boundary, so a PWM period
  // never mixes two patterns or two duty cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      seg_q      <= '0;
      pre_cnt    <= '0;
      pwm_cnt    <= '0;
      shadow_pat <= '0;
      shadow_br  <= '0;
    end else begin
      seg_q <= seg_in;
      if (pre_wrap) begin
        pre_cnt <= '0;
        pwm_cnt <= pwm_cnt + 1'b1;
      end else begin
        pre_cnt <= pre_cnt + 1'b1;
      end
      if (boundary) begin
        shadow_pat <= src_pat;
        shadow_br  <= bright;
      end
    end
  end

  // Any CTRL write restarts the blink so the digit is visible right away.
  always_ff @(posedge clk) begin
    if (reset || ctrl_wr) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == BLK_LAST) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hex_n <= 7'h7F;
    end else begin
      hex_n <= visible ? ~shadow_pat : 7'h7F;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_CTRL:   readdata = {29'd0, ctrl};
      ADDR_BRIGHT: readdata = {{(31 - PWM_BITS){1'b0}}, bright};
      ADDR_STATUS: readdata = {30'd0, pwm_on, blink_phase};
      default:     readdata = '0;
    endcase
  end

endmodule
